// File: rtl/keyboard_note_scanner.sv
// rtl/keyboard_note_scanner.sv - debounced key/octave scanner with note-select FSM
// Keys and octave buttons are synchronised, debounced, then resolved to one note.

module keyboard_note_scanner_debounce #(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            // A mismatch must persist for DEBOUNCE_CYCLES consecutive samples.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module keyboard_note_scanner #(
    parameter int NUM_KEYS        = 7,
    parameter int NOTE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                oct_up,
    input  logic                oct_down,
    input  logic                mode,
    output logic [NOTE_W-1:0]   note_out,
    output logic [1:0]          octave_out,
    output logic                note_valid,
    output logic                note_start,
    output logic [NUM_KEYS-1:0] led_out
);
    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_t;

    state_t              state;
    logic [NUM_KEYS-1:0] key_stable;
    logic                up_stable;
    logic                down_stable;
    logic                up_prev;
    logic                down_prev;
    logic                mode_q;
    logic [NOTE_W-1:0]   cand;
    logic [NOTE_W-1:0]   cand_low;
    logic [NUM_KEYS-1:0] cand_led;
    logic [NUM_KEYS-1:0] low_led;
    int                  ones;
    logic                up_rise;
    logic                down_rise;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        keyboard_note_scanner_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .din   (keys[i]),
            .stable(key_stable[i])
        );
    end

    keyboard_note_scanner_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .din   (oct_up),
        .stable(up_stable)
    );

    keyboard_note_scanner_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_down (
        .clk   (clk),
        .rst   (rst),
        .din   (oct_down),
        .stable(down_stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode;
        end
    end

    // Lowest set key wins in priority mode; exclusive mode only accepts a lone key.
    always_comb begin
        cand_low = '0;
        low_led  = '0;
        ones     = 0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_stable[i]) begin
                cand_low   = NOTE_W'(i + 1);
                low_led    = '0;
                low_led[i] = 1'b1;
                ones       = ones + 1;
            end
        end
        if (mode_q || ones == 1) begin
            cand     = cand_low;
            cand_led = low_led;
        end else begin
            cand     = '0;
            cand_led = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            note_out   <= '0;
            note_valid <= 1'b0;
            note_start <= 1'b0;
            led_out    <= '0;
        end else begin
            note_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (cand != '0) begin
                        state      <= PLAYING;
                        note_out   <= cand;
                        note_valid <= 1'b1;
                        led_out    <= cand_led;
                        note_start <= 1'b1;
                    end
                end
                PLAYING: begin
                    if (cand == '0) begin
                        state      <= IDLE;
                        note_out   <= '0;
                        note_valid <= 1'b0;
                        led_out    <= '0;
                    end else if (cand != note_out) begin
                        note_out   <= cand;
                        led_out    <= cand_led;
                        note_start <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    note_out   <= '0;
                    note_valid <= 1'b0;
                    led_out    <= '0;
                end
            endcase
        end
    end

    assign up_rise   = up_stable & ~up_prev;
    assign down_rise = down_stable & ~down_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            up_prev    <= 1'b0;
            down_prev  <= 1'b0;
            octave_out <= 2'd1;
        end else begin
            up_prev   <= up_stable;
            down_prev <= down_stable;
            // Simultaneous up and down edges cancel out.
            if (up_rise && !down_rise && octave_out != 2'd3) begin
                octave_out <= octave_out + 2'd1;
            end else if (down_rise && !up_rise && octave_out != 2'd0) begin
                octave_out <= octave_out - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_keyboard_note_scanner.sv
// tb/tb_keyboard_note_scanner.sv - scoreboard bench for keyboard_note_scanner
module tb_keyboard_note_scanner;
    localparam int NK = 7;
    localparam int NW = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] keys = '0;
    logic          oct_up = 1'b0;
    logic          oct_down = 1'b0;
    logic          mode = 1'b0;
    logic [NW-1:0] note_out;
    logic [1:0]    octave_out;
    logic          note_valid;
    logic          note_start;
    logic [NK-1:0] led_out;

    int checks = 0;
    int errors = 0;

    keyboard_note_scanner #(
        .NUM_KEYS(NK),
        .NOTE_W(NW),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keys      (keys),
        .oct_up    (oct_up),
        .oct_down  (oct_down),
        .mode      (mode),
        .note_out  (note_out),
        .octave_out(octave_out),
        .note_valid(note_valid),
        .note_start(note_start),
        .led_out   (led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int note;
        int valid;
        int start;
        int led;
        int oct;
    } exp_t;

    exp_t exp_q[$];

    function automatic int pick_note(input logic [NK-1:0] k, input logic prio);
        int low = 0;
        for (int i = NK - 1; i >= 0; i--)
            if (k[i]) low = i + 1;
        if (prio) return low;
        return ($countones(k) == 1) ? low : 0;
    endfunction

    // Reference model: stable input = last D synchronised samples all disagree -> flip.
    initial begin
        logic [NK+1:0] raw_q[$];
        logic [NK+1:0] seen_q[$];
        logic [NK+1:0] m_stable;
        logic [NK+1:0] m_prev;
        logic [NK+1:0] seen;
        logic          m_mode;
        int            m_note;
        int            m_oct;
        int            cand;
        bit            up;
        bit            dn;
        bit            all_diff;
        exp_t          e;
        m_stable = '0;
        m_prev   = '0;
        m_mode   = 1'b0;
        m_note   = 0;
        m_oct    = 1;
        forever begin
            @(posedge clk);
            if (rst) begin
                raw_q = '{'0, '0};
                seen_q.delete();
                m_stable = '0;
                m_prev   = '0;
                m_mode   = 1'b0;
                m_note   = 0;
                m_oct    = 1;
                e = '{0, 0, 0, 0, 1};
            end else begin
                cand    = pick_note(m_stable[NK-1:0], m_mode);
                e.note  = cand;
                e.valid = (cand != 0);
                e.start = (cand != 0 && cand != m_note);
                e.led   = (cand != 0) ? (1 << (cand - 1)) : 0;
                up = m_stable[NK] && !m_prev[NK];
                dn = m_stable[NK+1] && !m_prev[NK+1];
                if (up && !dn && m_oct < 3) m_oct++;
                else if (dn && !up && m_oct > 0) m_oct--;
                e.oct  = m_oct;
                m_note = cand;
                m_prev = m_stable;
                seen = raw_q[0];
                raw_q.push_back({oct_down, oct_up, keys});
                void'(raw_q.pop_front());
                seen_q.push_back(seen);
                if (seen_q.size() > D) void'(seen_q.pop_front());
                if (seen_q.size() == D) begin
                    for (int j = 0; j < NK + 2; j++) begin
                        all_diff = 1'b1;
                        for (int k = 0; k < D; k++)
                            if (seen_q[k][j] == m_stable[j]) all_diff = 1'b0;
                        if (all_diff) m_stable[j] = ~m_stable[j];
                    end
                end
                m_mode = mode;
            end
            exp_q.push_back(e);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("note_out", int'(note_out), e.note);
                chk("note_valid", int'(note_valid), e.valid);
                chk("note_start", int'(note_start), e.start);
                chk("led_out", int'(led_out), e.led);
                chk("octave_out", int'(octave_out), e.oct);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit up, input bit dn);
        oct_up   = up;
        oct_down = dn;
        wait_cycles(8);
        oct_up   = 1'b0;
        oct_down = 1'b0;
        wait_cycles(8);
    endtask

    initial begin
        int hold;
        int pat;
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(4);
        keys = 7'b0000100;
        wait_cycles(12);
        keys = 7'b0000000;
        wait_cycles(12);
        keys = 7'b0000001;
        wait_cycles(3);
        keys = 7'b0000000;
        wait_cycles(12);
        mode = 1'b0;
        keys = 7'b0010010;
        wait_cycles(12);
        mode = 1'b1;
        wait_cycles(6);
        keys = 7'b0010000;
        wait_cycles(12);
        keys = 7'b0000000;
        mode = 1'b0;
        wait_cycles(10);
        repeat (3) press(1'b1, 1'b0);
        repeat (4) press(1'b0, 1'b1);
        press(1'b1, 1'b1);
        keys = 7'b0001000;
        wait_cycles(10);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        keys = 7'b0100000;
        wait_cycles(12);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(12);
        keys = '0;
        wait_cycles(10);
        for (int n = 0; n < 500; n++) begin
            pat = $urandom_range(0, 9);
            if (pat < 3) keys = '0;
            else if (pat < 6) keys = NK'(1) << $urandom_range(0, NK - 1);
            else keys = NK'($urandom);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            oct_up   = ($urandom_range(0, 5) == 0);
            oct_down = ($urandom_range(0, 5) == 0);
            rst      = ($urandom_range(0, 49) == 0);
            hold = $urandom_range(1, 12);
            wait_cycles(1);
            rst = 1'b0;
            wait_cycles(hold);
        end
        wait_cycles(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
